mux4_1_rr_sched: RTL and testbench



---
 rtl/mux4_pkg.sv | 20 ++
 rtl/rr_pick4.sv | 35 +++
 rtl/mux4_1_rr_sched.sv | 127 ++++++++++++
 tb/tb_mux4_1_rr_sched.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mux4_pkg.sv
// Shared types and helpers for the four-way round-robin mux scheduler.
package mux4_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot encode a requester index.
  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set request at or after ptr, wrapping 3->0.
// With mask_owner set, index ptr-1 (the outgoing owner when ptr = owner+1)
// is excluded, so found then also means "someone other than the owner waits".
module rr_pick4
  import mux4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  input  logic               mask_owner,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  logic [NUM_REQ-1:0] masked;
  logic [SEL_W-1:0]   cand;

  // Search from the farthest slot back to ptr so the nearest hit wins.
  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    masked = req;
    cand   = '0;
    idx    = '0;
    found  = 1'b0;
    if (mask_owner) masked[ptr - SEL_W'(1)] = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (masked[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_1_rr_sched.sv
// Round-robin scheduler driving the select of a 4:1 data mux. Issues a
// registered one-hot grant, rotates priority on release, and forces a
// rotation once an owner has held the mux MAX_HOLD cycles while others wait.
module mux4_1_rr_sched
  import mux4_pkg::*;
#(
  parameter  int MAX_HOLD = 8,
  localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               gnt_start
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state, state_d;
  logic [SEL_W-1:0]   ptr, ptr_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [SEL_W-1:0]   sel_d;
  logic               sel_valid_d;
  logic               gnt_start_d;

  // While granted, sel is the owner; search starts just past it and skips it.
  logic               in_grant;
  logic [SEL_W-1:0]   pick_ptr;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_found;
  logic               owner_req;
  logic               take;

  assign in_grant  = (state == GRANT);
  assign pick_ptr  = in_grant ? sel + SEL_W'(1) : ptr;
  assign owner_req = req[sel];

  rr_pick4 u_pick (
    .req        (req),
    .ptr        (pick_ptr),
    .mask_owner (in_grant),
    .idx        (pick_idx),
    .found      (pick_found)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state: leave IDLE on any enabled request; leave GRANT only when
  // the owner releases and nobody can be handed the mux at the same edge.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (en && pick_found) state_d = GRANT;
      GRANT: if (!owner_req && !(en && pick_found)) state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs, pointer and hold counter.
  always_comb begin
    ptr_d       = ptr;
    cnt_d       = cnt;
    gnt_d       = gnt;
    sel_d       = sel;
    sel_valid_d = sel_valid;
    gnt_start_d = 1'b0;
    take        = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && pick_found) take = 1'b1;
      end
      GRANT: begin
        if (!owner_req) begin
          ptr_d = sel + SEL_W'(1);
          if (en && pick_found) begin
            take = 1'b1;
          end else begin
            gnt_d       = '0;
            sel_valid_d = 1'b0;
          end
        end else if (cnt == HOLD_MAX && en && pick_found) begin
          ptr_d = sel + SEL_W'(1);
          take  = 1'b1;
        end else if (cnt != HOLD_MAX) begin
          cnt_d = cnt + CNT_ONE;
        end
      end
    endcase
    if (take) begin
      gnt_d       = onehot4(pick_idx);
      sel_d       = pick_idx;
      sel_valid_d = 1'b1;
      gnt_start_d = 1'b1;
      cnt_d       = CNT_ONE;
    end
  end

  // Output and datapath registers; async reset drops any grant at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      gnt_start <= 1'b0;
    end else begin
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      gnt       <= gnt_d;
      sel       <= sel_d;
      sel_valid <= sel_valid_d;
      gnt_start <= gnt_start_d;
    end
  end

endmodule

// File: tb/tb_mux4_1_rr_sched.sv
// Self-checking bench for mux4_1_rr_sched with MAX_HOLD=4: directed steps
// followed by random traffic, all compared against a behavioural model.
module tb_mux4_1_rr_sched;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       sel_valid;
  logic       gnt_start;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner index (-1 when idle), priority pointer, hold
  // count, last select and whether the last edge began a new grant.
  int m_owner;
  int m_ptr;
  int m_cnt;
  int m_sel;
  bit m_start;

  mux4_1_rr_sched #(.MAX_HOLD(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .sel_valid (sel_valid),
    .gnt_start (gnt_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int search(input logic [3:0] r, input int from, input int skip);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (from + k) % 4;
      if (r[i] && i != skip) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_sel   = 0;
    m_start = 0;
  endtask

  task automatic model_give(input int w);
    m_owner = w;
    m_sel   = w;
    m_cnt   = 1;
    m_start = 1;
  endtask

  // Apply the scheduling rules for one clock edge using current inputs.
  task automatic model_step();
    int w;
    m_start = 0;
    if (m_owner < 0) begin
      w = en ? search(req, m_ptr, -1) : -1;
      if (w >= 0) model_give(w);
    end else if (!req[m_owner]) begin
      m_ptr = (m_owner + 1) % 4;
      w = en ? search(req, m_ptr, m_owner) : -1;
      if (w >= 0) model_give(w);
      else        m_owner = -1;
    end else begin
      w = search(req, (m_owner + 1) % 4, m_owner);
      if (m_cnt == HOLD && en && w >= 0) begin
        m_ptr = (m_owner + 1) % 4;
        model_give(w);
      end else if (m_cnt < HOLD) begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    chk({tag, ".gnt"},   gnt, eg);
    chk({tag, ".sel"},   {2'b00, sel}, 4'(m_sel));
    chk({tag, ".valid"}, {3'b000, sel_valid}, {3'b000, m_owner >= 0});
    chk({tag, ".start"}, {3'b000, gnt_start}, {3'b000, m_start});
  endtask

  // One clock: model the edge, let it happen, sample 1 time unit later.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [3:0] exp_g;

    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0000;
    model_reset();
    #12;
    check_model("reset");
    rst_n = 1'b1;

    // Single request from IDLE: one-cycle latency, one-cycle start pulse.
    en  = 1'b1;
    req = 4'b0100;
    cycle("t2_grant");
    chk("t2_gnt", gnt, 4'b0100);
    chk("t2_sel", {2'b00, sel}, 4'd2);
    chk("t2_start", {3'b000, gnt_start}, 4'd1);
    cycle("t2_hold");
    chk("t2_start_low", {3'b000, gnt_start}, 4'd0);

    // Asynchronous reset mid-grant, observed before the next edge.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t1_async_gnt", gnt, 4'b0000);
    chk("t1_async_sel", {2'b00, sel}, 4'd0);
    chk("t1_async_valid", {3'b000, sel_valid}, 4'd0);
    req = 4'b0000;
    #1 rst_n = 1'b1;
    cycle("t1_idle0");
    cycle("t1_idle1");

    // All four requesting: four-cycle turns, rotating 0,1,2,3,0.
    req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      cycle("t3_rr");
      exp_g = 4'b0001 << ((k / 4) % 4);
      chk("t3_seq", gnt, exp_g);
      chk("t3_pulse", {3'b000, gnt_start}, {3'b000, (k % 4) == 0});
    end

    // Rotate to owner 1, then owner 1 drops with 3 waiting.
    cycle("t4_rot");
    chk("t4_owner1", gnt, 4'b0010);
    req = 4'b1000;
    cycle("t4_handoff");
    chk("t4_gnt3", gnt, 4'b1000);
    chk("t4_sel3", {2'b00, sel}, 4'd3);
    req = 4'b0000;
    cycle("t4_idle");
    chk("t4_idle_gnt", gnt, 4'b0000);
    chk("t4_sel_held", {2'b00, sel}, 4'd3);
    chk("t4_idle_valid", {3'b000, sel_valid}, 4'd0);

    // Owner 3 releases with 0 pending: pointer wraps to 0.
    req = 4'b1000;
    cycle("t5_own3");
    req = 4'b1001;
    cycle("t5_keep3");
    chk("t5_still3", gnt, 4'b1000);
    req = 4'b0001;
    cycle("t5_wrap");
    chk("t5_gnt0", gnt, 4'b0001);
    chk("t5_sel0", {2'b00, sel}, 4'd0);

    // Enable low blocks new grants; raising it grants one cycle later.
    req = 4'b0000;
    cycle("t6_release");
    en  = 1'b0;
    req = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      cycle("t6_blocked");
      chk("t6_no_gnt", gnt, 4'b0000);
    end
    en = 1'b1;
    cycle("t6_enable");
    chk("t6_gnt1", gnt, 4'b0010);

    // Sole requester re-requesting after its release waits one idle cycle.
    req = 4'b0000;
    cycle("sole_release");
    chk("sole_idle", gnt, 4'b0000);
    req = 4'b0010;
    cycle("sole_regrant");
    chk("sole_gnt", gnt, 4'b0010);

    // Random traffic with occasional enable drops.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) < 3) req = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 9) != 0);
      cycle("rand");
      if (sel_valid) chk("rand_sel_gnt", gnt, 4'b0001 << sel);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
